delay_pipe_credit_buf: RTL and testbench
========================================

DELAY_PIPE_CREDIT_BUF -- requirements
Module: delay_pipe_credit_buf

Purpose: credit-managed return buffer placed directly downstream of the fixed-latency, non-stallable delay pipe. It grants issue into the pipe only when buffer space is guaranteed. It absorbs pipe output and presents it to a valid/ready consumer.

Interface
- REQ-001: Parameter W, default 32, data width in bits.
- REQ-002: Parameter N, default 5, latency of the upstream delay pipe in cycles. Informational only.
- REQ-003: Parameter D, default 8, buffer depth in entries. D >= 1, and D need not be a power of two.
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: rst  input  1  reset, asynchronous and active-low.
- REQ-006: issue_req  input  1  upstream source wants to issue one item into the delay pipe.
- REQ-007: issue_gnt  output  1  combinational; high = this cycle's issue is accepted and consumes one credit.
- REQ-008: pipe_vld  input  1  valid output of the delay pipe.
- REQ-009: pipe_dat  input  W  data output of the delay pipe.
- REQ-010: out_vld  output  1  buffer head valid, registered.
- REQ-011: out  output  W  buffer head data.
- REQ-012: out_rdy  input  1  consumer accepts the head.
- REQ-013: credit_r  output  $clog2(D+1)  registered count of available credits.
- REQ-014: full  output  1  occupancy == D.
- REQ-015: empty  output  1  occupancy == 0.
- REQ-016: ovf_err_r  output  1  sticky error flag: write attempted while full.

Function
- REQ-017: issue_gnt SHALL equal issue_req AND (credit_r != 0).
- REQ-018: Pop SHALL equal out_vld AND out_rdy.
- REQ-019: credit_r SHALL update each cycle as follows:
  - decrement by 1 on grant without pop;
  - increment by 1 on pop without grant;
  - hold when grant and pop coincide, or when neither occurs.
- REQ-020: credit_r SHALL never exceed D or go below 0. A pop that would exceed D is a design error and SHALL be flagged by assertion.
- REQ-021: pipe_vld SHALL write pipe_dat at the write pointer and advance that pointer. The pointer wraps from D-1 to 0.
- REQ-022: Pop SHALL advance the read pointer, which wraps from D-1 to 0.
- REQ-023: Occupancy SHALL change as follows:
  - +1 on write only;
  - -1 on pop only;
  - unchanged on simultaneous write and pop, including when occupancy is 1.
- REQ-024: Latency: a write in cycle t SHALL make out_vld high in cycle t+1. There is no same-cycle bypass, so a write into an empty buffer is not visible that cycle.
- REQ-025: out SHALL present the oldest unpopped entry whenever out_vld is high. Order is strict FIFO.
- REQ-026: out and out_vld SHALL hold stable while out_vld is high and out_rdy is low.
- REQ-027: pipe_vld while full and with no pop in the same cycle SHALL:
  - drop the write;
  - leave pointers and contents unchanged;
  - set ovf_err_r, which stays set until reset.
- REQ-028: The credit invariant SHALL hold every cycle: credit_r + occupancy + in-flight items == D.
- REQ-029: Full throughput (one item per cycle sustained with out_rdy tied high) SHALL be achieved when D >= N+2. The round trip is issue, N pipe cycles, 1 buffer cycle, then credit return.

Reset
- REQ-030: Asserting rst SHALL immediately force:
  - credit_r = D;
  - occupancy = 0 and both pointers = 0;
  - out_vld = 0, empty = 1, full = 0;
  - ovf_err_r = 0.
- REQ-031: Storage contents SHALL NOT be reset. out is don't-care while out_vld is low.
- REQ-032: Reset mid-operation SHALL discard all buffered and in-flight items and restore the full credit count.
  - The delay pipe is reset by the same source.
  - issue_gnt SHALL be low while rst is asserted.
- REQ-033: First grant possible in the first clock edge after rst deasserts.

Verification (N=5, D=8, W=32)
- REQ-034: Reset release with issue_req=0 -> credit_r=8, out_vld=0, empty=1, full=0, ovf_err_r=0.
- REQ-035: issue_req held high 10 cycles, out_rdy=0, items 0..9 -> issue_gnt high for 8 cycles then low; credit_r=0; after pipe latency full=1 and out=0 held.
- REQ-036: From REQ-035 state, out_rdy=1 for exactly 1 cycle -> item 0 popped; next cycle credit_r=1 and out=1; one further grant allowed.
- REQ-037: issue_req and out_rdy tied high for 50 cycles -> one grant every cycle after reset; credit_r settles at 1; outputs appear in issue order with no gaps once flowing.
- REQ-038: Force pipe_vld=1 with pipe_dat=0xDEADBEEF while full and out_rdy=0 -> ovf_err_r=1 and stays 1; occupancy stays 8; the next pops return the original data only.
- REQ-039: Assert rst with 3 items buffered and 2 in flight -> out_vld=0 and credit_r=8 at once; after release, the first issued item is the first item output.

Source files
------------

// File: rtl/delay_pipe_credit_buf.sv
// Credit-managed return buffer behind a fixed-latency, non-stallable delay pipe.
// Credits start at D and are only handed out when a buffer slot is guaranteed,
// so under correct use the pipe can never overrun the buffer.
module delay_pipe_credit_buf #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 5,
  parameter int unsigned D = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_req,
  output logic                   issue_gnt,
  input  logic                   pipe_vld,
  input  logic [W-1:0]           pipe_dat,
  output logic                   out_vld,
  output logic [W-1:0]           out,
  input  logic                   out_rdy,
  output logic [$clog2(D+1)-1:0] credit_r,
  output logic                   full,
  output logic                   empty,
  output logic                   ovf_err_r
);

  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;

  logic [CW-1:0] r_credit, w_credit_d;
  logic [CW-1:0] r_count, w_count_d;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [PW-1:0] r_rd_ptr, w_rd_ptr_d;
  logic          r_out_vld;
  logic          r_ovf;
  logic [W-1:0]  r_mem [D];

  logic w_gnt, w_pop, w_wr, w_full;

  // Handshakes, credit/occupancy next state and pointer advance
  always_comb begin
    w_full     = (r_count == CW'(D));
    // Gate on reset so no grant leaks out while the pipe is being flushed.
    w_gnt      = issue_req & rst & (r_credit != '0);
    w_pop      = r_out_vld & out_rdy;
    // A pop in the same cycle frees the slot, so a write into a full buffer is legal then.
    w_wr       = pipe_vld & (~w_full | w_pop);

    w_credit_d = r_credit;
    if (w_gnt && !w_pop) begin
      w_credit_d = r_credit - CW'(1);
    end else if (w_pop && !w_gnt) begin
      w_credit_d = r_credit + CW'(1);
    end

    w_count_d = r_count;
    if (w_wr && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (w_pop && !w_wr) begin
      w_count_d = r_count - CW'(1);
    end

    w_wr_ptr_d = r_wr_ptr;
    if (w_wr) begin
      w_wr_ptr_d = (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + PW'(1);
    end

    w_rd_ptr_d = r_rd_ptr;
    if (w_pop) begin
      w_rd_ptr_d = (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + PW'(1);
    end
  end

  // Control state; reset restores full credit and an empty buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit  <= CW'(D);
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_out_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_credit  <= w_credit_d;
      r_count   <= w_count_d;
      r_wr_ptr  <= w_wr_ptr_d;
      r_rd_ptr  <= w_rd_ptr_d;
      r_out_vld <= (w_count_d != '0);
      // Sticky: a dropped write means the credit loop was violated upstream.
      r_ovf     <= r_ovf | (pipe_vld & ~w_wr);
    end
  end

  // Storage array; contents deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= pipe_dat;
    end
  end

  // Output drive
  always_comb begin
    issue_gnt = w_gnt;
    out_vld   = r_out_vld;
    out       = r_mem[r_rd_ptr];
    credit_r  = r_credit;
    full      = w_full;
    empty     = (r_count == '0);
    ovf_err_r = r_ovf;
  end

  // A credit returned while already at D means a pop without a matching issue.
  a_credit_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(w_pop && !w_gnt && (r_credit == CW'(D))))
    else $error("credit overflow (D=%0d, N=%0d)", D, N);

  a_credit_bound : assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, r_credit} + {1'b0, r_count}) <= (CW + 1)'(D))
    else $error("credit + occupancy exceeds D");

endmodule

// File: tb/tb_delay_pipe_credit_buf.sv
// Bench for delay_pipe_credit_buf: models the delay pipe and a queue-based buffer,
// checks every cycle against the model plus directed table rows and sequences.
module tb_delay_pipe_credit_buf;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 5;
  localparam int unsigned D  = 8;
  localparam int          DI = 8;
  localparam int          PS = N + 1;  // issue register plus N pipe stages

  logic          clk, rst, issue_req, issue_gnt, pipe_vld, out_vld, out_rdy;
  logic          full, empty, ovf_err_r;
  logic [W-1:0]  pipe_dat, dout;
  logic [3:0]    credit_r;

  delay_pipe_credit_buf #(.W(W), .N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_req (issue_req),
    .issue_gnt (issue_gnt),
    .pipe_vld  (pipe_vld),
    .pipe_dat  (pipe_dat),
    .out_vld   (out_vld),
    .out       (dout),
    .out_rdy   (out_rdy),
    .credit_r  (credit_r),
    .full      (full),
    .empty     (empty),
    .ovf_err_r (ovf_err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic         sr_v [PS];
  logic [W-1:0] sr_d [PS];
  logic [W-1:0] next_id = 0;
  logic         m_ovf = 1'b0;
  logic         m_gnt, m_pop, m_wr;

  typedef struct {
    logic         req;
    logic         rdy;
    logic         gnt;
    logic [3:0]   cr;
    logic         vld;
    logic         full;
    logic         empty;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic req, input logic rdy, input logic gnt,
                             input logic [3:0] cr, input logic vld, input logic fl,
                             input logic em, input logic [W-1:0] d);
    vec_t r;
    r.req = req; r.rdy = rdy; r.gnt = gnt; r.cr = cr;
    r.vld = vld; r.full = fl; r.empty = em; r.dout = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < PS; i++) begin
      sr_v[i] = 1'b0;
      sr_d[i] = '0;
    end
    m_ovf = 1'b0;
  endtask

  // Drive inputs, then at the falling edge predict and compare everything.
  task automatic step_a(input logic req, input logic rdy, input logic frc);
    int infl;
    int cred;
    issue_req = req;
    out_rdy   = rdy;
    pipe_vld  = sr_v[PS-1] | frc;
    pipe_dat  = frc ? 32'hDEADBEEF : sr_d[PS-1];
    @(negedge clk);
    infl = 0;
    for (int i = 0; i < PS; i++) infl += int'(sr_v[i]);
    // Credit invariant: whatever is not buffered or in flight is available.
    cred  = DI - q.size() - infl;
    m_gnt = issue_req && (cred > 0);
    m_pop = (q.size() != 0) && out_rdy;
    m_wr  = pipe_vld && ((q.size() < DI) || m_pop);
    chk("m_gnt",    32'(issue_gnt), 32'(m_gnt));
    chk("m_credit", 32'(credit_r),  32'(cred));
    chk("m_vld",    32'(out_vld),   32'(q.size() != 0));
    chk("m_full",   32'(full),      32'(q.size() == DI));
    chk("m_empty",  32'(empty),     32'(q.size() == 0));
    chk("m_ovf",    32'(ovf_err_r), 32'(m_ovf));
    if (q.size() != 0) chk("m_data", dout, q[0]);
  endtask

  task automatic step_b();
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_wr) q.push_back(pipe_dat);
    if (pipe_vld && !m_wr) m_ovf = 1'b1;
    for (int i = PS - 1; i > 0; i--) begin
      sr_v[i] = sr_v[i-1];
      sr_d[i] = sr_d[i-1];
    end
    sr_v[0] = m_gnt;
    sr_d[0] = next_id;
    if (m_gnt) next_id++;
    #1;
  endtask

  task automatic step(input logic req, input logic rdy);
    step_a(req, rdy, 1'b0);
    step_b();
  endtask

  // Asynchronous reset pulse with immediate output checks; issue_req held high.
  task automatic rst_pulse(input string tag);
    issue_req = 1'b1;
    rst       = 1'b0;
    model_clear();
    pipe_vld  = 1'b0;
    #1;
    chk({tag, "_vld"},    32'(out_vld),   32'd0);
    chk({tag, "_credit"}, 32'(credit_r),  32'd8);
    chk({tag, "_empty"},  32'(empty),     32'd1);
    chk({tag, "_full"},   32'(full),      32'd0);
    chk({tag, "_ovf"},    32'(ovf_err_r), 32'd0);
    chk({tag, "_gnt"},    32'(issue_gnt), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    issue_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] first_id;
    logic         found;
    vec_t         r;

    rst = 1'b1; issue_req = 1'b0; out_rdy = 1'b0; pipe_vld = 1'b0; pipe_dat = '0;
    model_clear();
    #3;
    rst_pulse("rst0");

    // Fill to full with out_rdy low, one pop, one further grant, refill.
    tbl.push_back(v(0, 0, 0, 8, 0, 0, 1, 0));
    for (int c = 0; c < 7; c++) tbl.push_back(v(1, 0, 1, 4'(8 - c), 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0));
    for (int c = 10; c < 14; c++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 0, 1, 1, 1, 0, 0, 1));
    for (int c = 17; c < 23; c++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      step_a(r.req, r.rdy, 1'b0);
      chk($sformatf("tbl%0d_gnt", i),    32'(issue_gnt), 32'(r.gnt));
      chk($sformatf("tbl%0d_credit", i), 32'(credit_r),  32'(r.cr));
      chk($sformatf("tbl%0d_vld", i),    32'(out_vld),   32'(r.vld));
      chk($sformatf("tbl%0d_full", i),   32'(full),      32'(r.full));
      chk($sformatf("tbl%0d_empty", i),  32'(empty),     32'(r.empty));
      chk($sformatf("tbl%0d_ovf", i),    32'(ovf_err_r), 32'd0);
      if (r.vld) chk($sformatf("tbl%0d_out", i), dout, r.dout);
      step_b();
    end

    // Overflow: inject a write while full with no pop.
    step_a(1'b0, 1'b0, 1'b1);
    step_b();
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b0, 1'b0);
      chk("ovf_set",  32'(ovf_err_r), 32'd1);
      chk("ovf_full", 32'(full),      32'd1);
      chk("ovf_head", dout,           32'd1);
      step_b();
    end
    for (int k = 0; k < 8; k++) begin
      step_a(1'b0, 1'b1, 1'b0);
      chk("ovf_drain", dout, 32'(k + 1));
      chk("ovf_sticky", 32'(ovf_err_r), 32'd1);
      step_b();
    end
    step_a(1'b0, 1'b0, 1'b0);
    chk("ovf_drained_empty", 32'(empty), 32'd1);
    step_b();

    // Reset with 3 items buffered and 2 in flight.
    rst_pulse("rst1");
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("mid_credit", 32'(credit_r), 32'd3);
    chk("mid_vld",    32'(out_vld),  32'd1);
    rst_pulse("rst_mid");
    first_id = next_id;
    step(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step_a(1'b0, 1'b1, 1'b0);
      if (out_vld) begin
        chk("post_rst_first", dout, first_id);
        found = 1'b1;
      end
      step_b();
    end
    chk("post_rst_seen", 32'(found), 32'd1);

    // Sustained throughput with issue_req and out_rdy tied high.
    rst_pulse("rst2");
    base = next_id;
    for (int i = 0; i < 50; i++) begin
      step_a(1'b1, 1'b1, 1'b0);
      chk("tput_gnt", 32'(issue_gnt), 32'd1);
      if (i >= 7) begin
        chk("tput_credit", 32'(credit_r), 32'd1);
        chk("tput_vld",    32'(out_vld),  32'd1);
        chk("tput_order",  dout,          base + 32'(i - 7));
      end
      step_b();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(9) < 6));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b0);
    chk("final_empty",  32'(empty),    32'd1);
    chk("final_credit", 32'(credit_r), 32'd8);
    step_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
